ram_sdp_be_clr: RTL
===================

# ram_sdp_be_clr

Parametrised simple-dual-port inferred RAM with per-lane write enables, selectable read latency and a hardware clear sequencer. On reset it sweeps every word to a fixed value before it accepts traffic. It is the next generation of the fixed 512x16 inferred-RAM test blocks in the inferred RAM benchmark set. It targets block-RAM inference at arbitrary width and depth, with deterministic post-reset contents and no `$readmemh` dependence.

## Interface
- `ADDR_W`, default 9: address width; depth DEPTH = 2^ADDR_W.
- `DATA_W`, default 16: word width.
- `BYTE_W`, default 8: write-lane width. DATA_W % BYTE_W must be 0, otherwise elaboration fails. NLANE = DATA_W/BYTE_W.
- `REG_RD`, default 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- `CLEAR_VAL`, default 0: DATA_W-bit value written to every word by the clear sweep.
- `Clk`  in  1  single clock for all logic.
- `Rst`  in  1  synchronous, active-high reset.
- `WA`  in  ADDR_W  write address.
- `WD`  in  DATA_W  write data.
- `WEN`  in  NLANE  lane write enables; bit i covers bits [i*BYTE_W +: BYTE_W].
- `WClk_En`  in  1  write-port enable; qualifies WEN.
- `RA`  in  ADDR_W  read address.
- `RClk_En`  in  1  read request.
- `RD`  out  DATA_W  read data.
- `RD_Valid`  out  1  RD holds data for a request accepted REG_RD+1 cycles earlier.
- `Busy`  out  1  clear sweep in progress; port traffic is ignored.

## Operation
- The FSM has two states, CLEAR and RUN, and a clear pointer `ptr` of ADDR_W bits.
- Rst high at an edge:
  - state goes to CLEAR and ptr to 0;
  - RD, RD_Valid and every pipeline stage (data and valid) go to 0;
  - Busy=1;
  - no memory write occurs while Rst is high.
- CLEAR with Rst low:
  - each edge writes CLEAR_VAL to mem[ptr] and increments ptr;
  - on the edge that writes ptr==DEPTH-1, state goes to RUN.
- Rst asserted mid-sweep restarts the sweep at address 0. Rst asserted in RUN re-clears the whole array.
- RUN, write: each lane i with WClk_En & WEN[i] updates that lane of mem[WA]. Lanes not enabled keep their old value. WClk_En=0 or WEN=0 causes no write.
- RUN, read: when RClk_En=1, mem[RA] is captured and a valid token enters the read pipe. When RClk_En=0, a bubble (valid 0) enters the pipe and the data stage keeps its value.
- RD holds its last value when there is no new valid. RD_Valid is 1 only in cycles that carry fresh data.
- During CLEAR, WClk_En, WEN and RClk_En are ignored: no write, and no valid token enters the read pipe.
- Read and write to the same address in the same edge: the read returns the pre-write word (read-first) unless RAM_WR_BYPASS_EN is set (see Configuration).
- Distinct WA and RA never interact.

## Timing
- Busy is 1 from the Rst edge. It stays 1 for exactly DEPTH edges after the first edge with Rst low, then falls. With ADDR_W=9, Busy falls 512 cycles after Rst release.
- The first request can be accepted on the edge after Busy reads 0.
- REG_RD=0: request at edge N gives RD/RD_Valid updated at edge N. Data is visible in cycle N+1.
- REG_RD=1: data is visible one cycle later, in cycle N+2.
- Throughput is one read and one write per cycle. Back-to-back reads produce back-to-back RD_Valid.
- Writes take effect at the edge. A read of that address at any later edge sees the new data.

## Configuration
- `RAM_WR_BYPASS_EN` defined: on the same-address same-edge case, RD returns the merged word. Written lanes take WD; unwritten lanes take the old mem value (write-first, per lane).
- `RAM_WR_BYPASS_EN` undefined: read-first behaviour, with no forwarding logic.
- The macro does not affect the clear sweep or latency.

## Test plan
- **Clear:** pulse Rst 3 cycles, then wait. Busy=1 for exactly 512 cycles after release. Reading all 512 addresses returns 0x0000 with RD_Valid each cycle.
- **Lane write:** write WA=0x005, WD=0xABCD, WEN=2'b01, then WEN=2'b10 with WD=0x12FF. Reading 0x005 gives 0x1234?? This case is invalid as written. Use instead: WEN=2'b01 with WD=0xABCD, then WEN=2'b10 with WD=0x1200. Reading 0x005 gives 0x12CD.
- **Latency:** with REG_RD=0 and REG_RD=1, issue back-to-back reads of 0x001..0x004. RD_Valid appears 1 and 2 cycles after the requests respectively, with no gaps and data in order.
- **Collision:** mem[0x010]=0x0000; write WD=0xBEEF, WEN=2'b10, and read RA=0x010 on the same edge. RD=0x0000 without the macro; RD=0xBE00 with `RAM_WR_BYPASS_EN`.
- **Reset mid-sweep:** assert Rst at sweep address 200. Busy stays high for 512 more cycles after release. Writes and reads attempted while Busy is high leave mem at CLEAR_VAL and RD_Valid at 0.
- **Parameter corner:** ADDR_W=4, DATA_W=32, BYTE_W=8, CLEAR_VAL=0xA5A5A5A5. Busy lasts 16 cycles. Writing WEN=4'b0100 with WD=0x00330000 reads back 0xA533A5A5.

Source files
------------

// File: rtl/ram_sdp_be_clr_if.sv
// ---------------------------------------------------------------------------
// ram_sdp_be_clr_if
//   Port bundle for the simple-dual-port byte-enable RAM with clear sweep.
//
//   Parameters must match those given to the ram_sdp_be_clr instance that
//   uses this bundle (ADDR_W, DATA_W, BYTE_W).
//
//   Signals (direction as seen from the RAM, i.e. the slave modport):
//     WA       in  ADDR_W  write address
//     WD       in  DATA_W  write data
//     WEN      in  NLANE   per-lane write enables
//     WClk_En  in  1       write-port enable, qualifies WEN
//     RA       in  ADDR_W  read address
//     RClk_En  in  1       read request
//     RD       out DATA_W  read data
//     RD_Valid out 1       RD carries fresh data this cycle
//     Busy     out 1       clear sweep in progress, traffic ignored
// ---------------------------------------------------------------------------
interface ram_sdp_be_clr_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8
);
  localparam int NLANE = DATA_W / BYTE_W;

  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic [NLANE-1:0]  WEN;
  logic              WClk_En;
  logic [ADDR_W-1:0] RA;
  logic              RClk_En;
  logic [DATA_W-1:0] RD;
  logic              RD_Valid;
  logic              Busy;

  // Traffic source (user logic / testbench).
  modport master (
    output WA, WD, WEN, WClk_En, RA, RClk_En,
    input  RD, RD_Valid, Busy
  );

  // The RAM itself.
  modport slave (
    input  WA, WD, WEN, WClk_En, RA, RClk_En,
    output RD, RD_Valid, Busy
  );
endinterface

// File: rtl/ram_sdp_be_clr.sv
// ---------------------------------------------------------------------------
// ram_sdp_be_clr
//   Simple-dual-port inferred RAM with per-lane write enables, selectable
//   read latency and a hardware clear sequencer. After reset every word is
//   swept to CLEAR_VAL before port traffic is accepted, so contents are
//   deterministic without any memory initialisation file.
//
//   Parameters:
//     ADDR_W    address width, DEPTH = 2**ADDR_W
//     DATA_W    word width
//     BYTE_W    write-lane width, must divide DATA_W
//     REG_RD    0: 1-cycle read latency, 1: extra output register (2 cycles)
//     CLEAR_VAL value written to every word by the clear sweep
//
//   Ports:
//     Clk   in   single clock
//     Rst   in   synchronous active-high reset, starts a clear sweep
//     bus   slave modport of ram_sdp_be_clr_if (WA/WD/WEN/WClk_En write
//           port, RA/RClk_En read port, RD/RD_Valid read result, Busy)
//
//   Optional feature macro:
//     RAM_WR_BYPASS_EN  when defined, a read and write to the same address
//                       on the same edge return the merged (write-first per
//                       lane) word; otherwise the read returns the old word.
// ---------------------------------------------------------------------------
module ram_sdp_be_clr #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 16,
  parameter int                BYTE_W    = 8,
  parameter int                REG_RD    = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic               Clk,
  input  logic               Rst,
  ram_sdp_be_clr_if.slave    bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NLANE = DATA_W / BYTE_W;

  // Elaboration-time parameter sanity checks.
  generate
    if (DATA_W % BYTE_W != 0) begin : g_bad_lane_width
      $error("ram_sdp_be_clr: DATA_W must be a multiple of BYTE_W");
    end
    if (REG_RD != 0 && REG_RD != 1) begin : g_bad_reg_rd
      $error("ram_sdp_be_clr: REG_RD must be 0 or 1");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Clear / run FSM
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;

  // Decoded controls from the output process.
  logic                busy;
  logic                clr_we;     // write CLEAR_VAL to mem[ptr_q]
  logic [NLANE-1:0]    wr_lane;    // qualified per-lane write strobes
  logic                rd_req;     // accepted read request

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        // The edge that writes the last word hands over to RUN; ptr wraps
        // back to 0, which is harmless because RUN never uses it.
        if (&ptr_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Output logic. Rst gates every memory and pipe action so that nothing
  // is written or accepted on an edge where reset is sampled high.
  always_comb begin
    busy    = (state_q == ST_CLEAR);
    clr_we  = busy && !Rst;
    wr_lane = '0;
    rd_req  = 1'b0;
    if (!busy && !Rst) begin
      if (bus.WClk_En) begin
        wr_lane = bus.WEN;
      end
      rd_req = bus.RClk_En;
    end
  end

  assign bus.Busy = busy;

  // -------------------------------------------------------------------------
  // Storage. Kept free of reset so it maps onto block RAM; the clear sweep
  // provides the deterministic contents instead.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge Clk) begin
    if (clr_we) begin
      mem[ptr_q] <= CLEAR_VAL;
    end else begin
      for (int i = 0; i < NLANE; i++) begin
        if (wr_lane[i]) begin
          mem[bus.WA][i*BYTE_W +: BYTE_W] <= bus.WD[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path, stage 1 (always present).
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] rd1_q;
  logic              rd1_vld_q;

`ifdef RAM_WR_BYPASS_EN
  // Same-address collision: each written lane forwards WD, the rest keep
  // the stored word, giving write-first behaviour per lane.
  logic              rd_hit;
  logic [DATA_W-1:0] rd_fwd;

  assign rd_hit = (bus.WA == bus.RA);

  generate
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_fwd_lane
      assign rd_fwd[gi*BYTE_W +: BYTE_W] =
        (rd_hit && wr_lane[gi]) ? bus.WD[gi*BYTE_W +: BYTE_W]
                                : mem[bus.RA][gi*BYTE_W +: BYTE_W];
    end
  endgenerate
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd1_q     <= '0;
      rd1_vld_q <= 1'b0;
    end else begin
      rd1_vld_q <= rd_req;
      // Data stage holds through bubbles so RD keeps its last value.
      if (rd_req) begin
`ifdef RAM_WR_BYPASS_EN
        rd1_q <= rd_fwd;
`else
        rd1_q <= mem[bus.RA];
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional output register (REG_RD=1).
  // -------------------------------------------------------------------------
  generate
    if (REG_RD != 0) begin : g_out_reg
      logic [DATA_W-1:0] rd2_q;
      logic              rd2_vld_q;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          rd2_q     <= '0;
          rd2_vld_q <= 1'b0;
        end else begin
          rd2_vld_q <= rd1_vld_q;
          if (rd1_vld_q) begin
            rd2_q <= rd1_q;
          end
        end
      end

      assign bus.RD       = rd2_q;
      assign bus.RD_Valid = rd2_vld_q;
    end else begin : g_no_out_reg
      assign bus.RD       = rd1_q;
      assign bus.RD_Valid = rd1_vld_q;
    end
  endgenerate

endmodule
